// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/product widths and multiplier FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   MUL_WIDTH   operand width of the iterative multiplier
//   PROD_WIDTH  product / adder datapath width
//   CNT_WIDTH   iteration counter width, clog2(MUL_WIDTH)
//   mul_state_e multiplier FSM states (IDLE=0, RUN=1, DONE=2)
package alu_pkg;

    localparam int MUL_WIDTH  = 32;
    localparam int PROD_WIDTH = 2 * MUL_WIDTH;
    localparam int CNT_WIDTH  = $clog2(MUL_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/sixty_four_bit_adder.sv
// Purely combinational 64-bit adder shared by the ALU datapath.
// Latency: 0 cycles (combinational).
// Backpressure: none; no handshake.
//
// Ports:
//   a    in  64  addend
//   b    in  64  addend
//   sum  out 64  a + b, modulo 2^64 (carry-out is dropped; callers keep sums in range)
module sixty_four_bit_adder
    import alu_pkg::*;
(
    input  logic [PROD_WIDTH-1:0] a,
    input  logic [PROD_WIDTH-1:0] b,
    output logic [PROD_WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned 32x32->64 shift-and-add multiplier, one multiplier bit per cycle.
// Latency: operands accepted at edge N, out_valid high after edge N+32; next accept at N+34 earliest.
// Backpressure: in_ready only in IDLE; product and out_valid held in DONE until out_ready.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous active-high reset, wins over every other event
//   in_valid   in   1   operands a/b valid
//   in_ready   out  1   operands accepted (high only in IDLE)
//   a          in   32  multiplicand, unsigned
//   b          in   32  multiplier, unsigned
//   out_valid  out  1   product valid (high only in DONE)
//   out_ready  in   1   consumer accepts product
//   product    out  64  a*b, unsigned; keeps its last value after the handshake
module shift_add_multiplier
    import alu_pkg::*;
#(
    // Only 32 is supported: the shared adder is fixed at 64 bits.
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    mul_state_e              state_q,   state_d;
    logic [2*WIDTH-1:0]      mcand_q,   mcand_d;
    logic [WIDTH-1:0]        mplier_q,  mplier_d;
    logic [2*WIDTH-1:0]      acc_q,     acc_d;
    logic [CNT_W-1:0]        count_q,   count_d;
    logic [2*WIDTH-1:0]      product_q, product_d;
    logic [2*WIDTH-1:0]      adder_sum;

    // acc never exceeds (2^32-1)^2, so dropping the adder carry-out loses nothing.
    sixty_four_bit_adder u_adder (
        .a   (acc_q),
        .b   (mcand_q),
        .sum (adder_sum)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end

            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = adder_sum;
                end
                // mcand is double width, so 31 left shifts never push a set bit out.
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                // Last bit: capture the final accumulation straight into the output
                // register so product is valid on the same edge DONE is entered.
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    product_d = acc_d;
                    state_d   = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Decoded from the state register only, so the two handshakes are mutually exclusive.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier with a queue scoreboard.
// Latency: checks 32-cycle accept-to-valid and 34-cycle back-to-back spacing.
// Backpressure: exercises held DONE, ignored operands, reset mid-operation.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    shift_add_multiplier dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    // Called at a negedge while in IDLE; returns at the negedge after the accept edge.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sb_q.push_back({32'b0, x} * {32'b0, y});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts negedges until out_valid; -1 if it never arrives.
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (!out_valid) cycles = -1;
    endtask

    task automatic pop_exp(output logic [63:0] e);
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = 64'hDEAD_DEAD_DEAD_DEAD;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (product !== 64'd0) begin errors++; $display("FAIL reset_product got %h want 0", product); end
    endtask

    task automatic test_basic;
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [63:0] ve [4];
        logic [63:0] e;
        int lat;
        va = '{32'd3, 32'hFFFF_FFFF, 32'd0,          32'h8000_0000};
        vb = '{32'd5, 32'hFFFF_FFFF, 32'h1234_5678,  32'd1};
        ve = '{64'd15, 64'hFFFF_FFFE_0000_0001, 64'd0, 64'h0000_0000_8000_0000};
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i]);
            wait_result(lat);
            pop_exp(e);
            checks++;
            if (lat !== 32) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 32", i, lat); end
            checks++;
            if (product !== ve[i]) begin errors++; $display("FAIL basic_const[%0d] got %h want %h", i, product, ve[i]); end
            checks++;
            if (product !== e) begin errors++; $display("FAIL basic_model[%0d] got %h want %h", i, product, e); end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] e;
        int lat;
        start_op(32'd1234, 32'd5678);
        wait_result(lat);
        pop_exp(e);
        checks++;
        if (product !== e) begin errors++; $display("FAIL bp_product got %h want %h", product, e); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== e) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b r=%b p=%h want v=1 r=0 p=%h", i, out_valid, in_ready, product, e);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        end
        checks++;
        if (product !== e) begin errors++; $display("FAIL bp_keep got %h want %h", product, e); end
    endtask

    task automatic test_reset_midrun;
        logic [63:0] e;
        int lat;
        bit  seen;
        start_op(32'h0000_DEAD, 32'h0000_BEEF);
        repeat (16) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_busy got r=%b v=%b want r=0 v=0", in_ready, out_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pop_exp(e);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 64'd0) begin
            errors++;
            $display("FAIL midrun_reset got r=%b v=%b p=%h want r=1 v=0 p=0", in_ready, out_valid, product);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midrun_no_pulse got out_valid pulse want none"); end
        start_op(32'd7, 32'd9);
        wait_result(lat);
        pop_exp(e);
        checks++;
        if (lat !== 32) begin errors++; $display("FAIL after_reset_latency got %0d want 32", lat); end
        checks++;
        if (product !== 64'd63 || product !== e) begin
            errors++;
            $display("FAIL after_reset_product got %h want %h", product, 64'd63);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_ignore;
        logic [63:0] e;
        int lat;
        start_op(32'd1000, 32'd3);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = $urandom;
            b        = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_result(lat);
        pop_exp(e);
        checks++;
        if (lat + 20 !== 32) begin errors++; $display("FAIL ignore_latency got %0d want 32", lat + 20); end
        checks++;
        if (product !== e || product !== 64'd3000) begin
            errors++;
            $display("FAIL ignore_product got %h want %h", product, e);
        end
        // Offer new operands together with out_ready in DONE: must wait for IDLE.
        in_valid  = 1'b1;
        a         = 32'd11;
        b         = 32'd13;
        out_ready = 1'b1;
        sb_q.push_back(64'd143);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_to_idle got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL held_accept got in_ready=%b want 0", in_ready); end
        wait_result(lat);
        pop_exp(e);
        checks++;
        if (lat !== 32 || product !== e) begin
            errors++;
            $display("FAIL held_result got lat=%0d p=%h want lat=32 p=%h", lat, product, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [63:0] e;
        logic [31:0] x;
        logic [31:0] y;
        int  lat;
        time t_prev;
        time t_now;
        t_prev = 0;
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 50 == 1) x = 32'hFFFF_FFFF;
            if (i % 70 == 2) y = 32'd0;
            t_now = $time;
            start_op(x, y);
            if (i > 0) begin
                checks++;
                if (t_now - t_prev !== 340) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d] got %0t want 340", i, t_now - t_prev);
                end
            end
            t_prev = t_now;
            wait_result(lat);
            pop_exp(e);
            checks++;
            if (lat !== 32 || product !== e) begin
                errors++;
                $display("FAIL rand[%0d] %h*%h got lat=%0d p=%h want lat=32 p=%h", i, x, y, lat, product, e);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_midrun();
        test_ignore();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
